pool_dma_engine: RTL and testbench

//  Parametrised CNN pooling accelerator; CPU-facing Avalon-MM slave, SDRAM-facing Avalon-MM master.

---
 rtl/pool_dma_engine.sv | 213 +++++++++++++++++++++
 tb/tb_pool_dma_engine.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_dma_engine.sv
// Purpose: KxK max/average pooling DMA. CPU slave registers; SDRAM master reads windows and writes results.
// Latency: K*K reads + 1 write per output (no stalls); 2 cycles of job overhead for CHECK and DONE.
// Backpressure: master_waitrequest holds the current address/strobe/data stable; the slave never stalls.
// Ports: clk/reset (async active-low); slave_* = Avalon-MM register port; master_* = Avalon-MM memory
//        port; irq = done & irq_en.
module pool_dma_engine #(
  parameter int DATA_W = 32,
  parameter int K      = 2,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  output logic              slave_waitrequest,
  input  logic [2:0]        slave_address,
  input  logic              slave_read,
  output logic [31:0]       slave_readdata,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  input  logic              master_waitrequest,
  output logic [31:0]       master_address,
  output logic              master_read,
  input  logic [DATA_W-1:0] master_readdata,
  output logic              master_write,
  output logic [DATA_W-1:0] master_writedata,
  output logic              irq
);

  localparam int LOGK  = (K == 4) ? 2 : 1;
  localparam int SH    = 2 * LOGK;
  localparam int ACC_W = DATA_W + SH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_RD    = 3'd2,
    S_WR    = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, next_state;

  // Configuration registers
  logic [31:0]      src_base, dst_base;
  logic [CNT_W-1:0] ch_num, w_num;
  logic             mode, irq_en, done;

  // Job counters
  logic [CNT_W-1:0] ch, oy, ox;
  logic [LOGK-1:0]  kx, ky;
  logic [31:0]      out_idx;
  logic [ACC_W-1:0] acc;

  logic busy;
  assign busy = (state != S_IDLE);

  // Register writes
  logic wr_ctrl, start;
  assign wr_ctrl = slave_write && (slave_address == 3'd0);
  assign start   = wr_ctrl && !busy && slave_writedata[0];

  // Output geometry: W/K is a shift because K is a power of two
  logic [CNT_W-1:0] wo;
  assign wo = w_num >> LOGK;

  logic win_last, ox_last, oy_last, ch_last, first_elem;
  assign win_last   = (kx == LOGK'(K-1)) && (ky == LOGK'(K-1));
  assign first_elem = (kx == '0) && (ky == '0);
  assign ox_last    = (ox == wo - CNT_W'(1));
  assign oy_last    = (oy == wo - CNT_W'(1));
  assign ch_last    = (ch == ch_num - CNT_W'(1));

  logic rd_acc, wr_acc;
  assign rd_acc = (state == S_RD) && !master_waitrequest;
  assign wr_acc = (state == S_WR) && !master_waitrequest;

  // Source element index: (ch*W + oy*K + ky)*W + ox*K + kx, all modulo 2^32
  logic [31:0] row_idx, elem_idx, rd_addr, wr_addr;
  assign row_idx  = 32'(ch) * 32'(w_num) + (32'(oy) << LOGK) + 32'(ky);
  assign elem_idx = row_idx * 32'(w_num) + (32'(ox) << LOGK) + 32'(kx);
  assign rd_addr  = src_base + (elem_idx << 2);
  assign wr_addr  = dst_base + (out_idx << 2);

  // Fold datapath: sign-extend to the accumulator width so AVG sums cannot overflow
  logic [ACC_W-1:0]        rd_ext;
  logic signed [ACC_W-1:0] avg_sh;
  logic [DATA_W-1:0]       result;
  assign rd_ext = {{SH{master_readdata[DATA_W-1]}}, master_readdata};
  assign avg_sh = $signed(acc) >>> SH;
  assign result = mode ? avg_sh[DATA_W-1:0] : acc[DATA_W-1:0];

  // Master outputs decode straight from state so they fall with an asynchronous reset
  assign master_read      = (state == S_RD);
  assign master_write     = (state == S_WR);
  assign master_address   = (state == S_RD) ? rd_addr :
                            (state == S_WR) ? wr_addr : 32'd0;
  assign master_writedata = (state == S_WR) ? result : '0;

  assign slave_waitrequest = 1'b0;
  assign irq               = done & irq_en;

  always_comb begin
    slave_readdata = 32'd0;
    if (slave_read) begin
      case (slave_address)
        3'd0:    slave_readdata = {29'b0, irq_en, mode, busy};
        3'd1:    slave_readdata = src_base;
        3'd2:    slave_readdata = dst_base;
        3'd3:    slave_readdata = 32'(ch_num);
        3'd4:    slave_readdata = 32'(w_num);
        3'd5:    slave_readdata = {30'b0, done, busy};
        default: slave_readdata = 32'd0;
      endcase
    end
  end

  // FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_CHECK;
      S_CHECK: next_state = ((ch_num == '0) || (w_num < CNT_W'(K))) ? S_DONE : S_RD;
      S_RD:    if (rd_acc && win_last) next_state = S_WR;
      S_WR:    if (wr_acc) next_state = (ox_last && oy_last && ch_last) ? S_DONE : S_RD;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Configuration registers and done flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_base <= 32'd0;
      dst_base <= 32'd0;
      ch_num   <= '0;
      w_num    <= '0;
      mode     <= 1'b0;
      irq_en   <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (slave_write && !busy) begin
        case (slave_address)
          3'd0: begin
            mode   <= slave_writedata[1];
            irq_en <= slave_writedata[2];
            done   <= 1'b0;
          end
          3'd1: src_base <= slave_writedata;
          3'd2: dst_base <= slave_writedata;
          3'd3: ch_num   <= slave_writedata[CNT_W-1:0];
          3'd4: w_num    <= slave_writedata[CNT_W-1:0];
          default: ;
        endcase
      end
      // STATUS clears done even mid-job
      if (slave_write && (slave_address == 3'd5)) done <= 1'b0;
      // Completion takes priority over a simultaneous clear
      if (state == S_DONE) done <= 1'b1;
    end
  end

  // Window/output counters and accumulator
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch      <= '0;
      oy      <= '0;
      ox      <= '0;
      kx      <= '0;
      ky      <= '0;
      out_idx <= 32'd0;
      acc     <= '0;
    end else begin
      if (state == S_CHECK) begin
        ch      <= '0;
        oy      <= '0;
        ox      <= '0;
        kx      <= '0;
        ky      <= '0;
        out_idx <= 32'd0;
      end
      if (rd_acc) begin
        if (first_elem)
          acc <= rd_ext;
        else if (mode)
          acc <= acc + rd_ext;
        else if ($signed(rd_ext) > $signed(acc))
          acc <= rd_ext;
        // kx/ky wrap naturally at K because K is a power of two
        kx <= kx + LOGK'(1);
        if (kx == LOGK'(K-1)) ky <= ky + LOGK'(1);
      end
      if (wr_acc) begin
        out_idx <= out_idx + 32'd1;
        if (ox_last) begin
          ox <= '0;
          if (oy_last) begin
            oy <= '0;
            ch <= ch + CNT_W'(1);
          end else begin
            oy <= oy + CNT_W'(1);
          end
        end else begin
          ox <= ox + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pool_dma_engine.sv
module tb_pool_dma_engine;
  localparam int DATA_W = 32;
  localparam int K      = 2;
  localparam int CNT_W  = 12;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              slave_waitrequest;
  logic [2:0]        slave_address = '0;
  logic              slave_read = 1'b0;
  logic [31:0]       slave_readdata;
  logic              slave_write = 1'b0;
  logic [31:0]       slave_writedata = '0;
  logic              master_waitrequest;
  logic [31:0]       master_address;
  logic              master_read;
  logic [DATA_W-1:0] master_readdata;
  logic              master_write;
  logic [DATA_W-1:0] master_writedata;
  logic              irq;

  always #5 clk = ~clk;

  pool_dma_engine #(.DATA_W(DATA_W), .K(K), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .slave_waitrequest(slave_waitrequest), .slave_address(slave_address),
    .slave_read(slave_read), .slave_readdata(slave_readdata),
    .slave_write(slave_write), .slave_writedata(slave_writedata),
    .master_waitrequest(master_waitrequest), .master_address(master_address),
    .master_read(master_read), .master_readdata(master_readdata),
    .master_write(master_write), .master_writedata(master_writedata),
    .irq(irq)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:1023];

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  int          rd_count = 0, wr_count = 0, origin_reads = 0;
  logic [31:0] origin_a = 32'hFFFF_FFF0, origin_b = 32'hFFFF_FFF0;
  int          rd_stall_idx = -1, rd_stall_len = 0, wr_stall_idx = -1, wr_stall_len = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: serves reads, scoreboards writes, injects stalls, checks stability
  initial begin : responder
    logic        in_xfer;
    logic        h_rd;
    logic [31:0] h_addr, h_data;
    int          stall_left;
    wr_t         e;
    in_xfer = 1'b0; h_rd = 1'b0; h_addr = '0; h_data = '0; stall_left = 0;
    master_waitrequest = 1'b0;
    master_readdata    = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        in_xfer = 1'b0;
        master_waitrequest = 1'b0;
        continue;
      end
      if (master_read || master_write) begin
        check("rd_wr_exclusive", {31'b0, master_read & master_write}, 32'd0);
        if (!in_xfer) begin
          in_xfer = 1'b1;
          h_rd = master_read;
          h_addr = master_address;
          h_data = master_writedata;
          if (master_read && rd_count == rd_stall_idx)       stall_left = rd_stall_len;
          else if (master_write && wr_count == wr_stall_idx) stall_left = wr_stall_len;
          else                                               stall_left = 0;
        end else begin
          check("addr_stable", master_address, h_addr);
          check("strobe_stable", {31'b0, master_read}, {31'b0, h_rd});
          if (!h_rd) check("wdata_stable", master_writedata, h_data);
        end
        if (stall_left > 0) begin
          master_waitrequest = 1'b1;
          stall_left--;
        end else begin
          master_waitrequest = 1'b0;
          in_xfer = 1'b0;
          if (master_read) begin
            master_readdata = mem[master_address[11:2]];
            rd_count++;
            if (master_address == origin_a || master_address == origin_b) origin_reads++;
          end else begin
            wr_count++;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $error("FAIL unexpected_write observed addr=%0h data=%0h expected none",
                     master_address, master_writedata);
            end else begin
              e = exp_q.pop_front();
              check("wr_addr", master_address, e.addr);
              check("wr_data", master_writedata, e.data);
            end
          end
        end
      end else begin
        master_waitrequest = 1'b0;
        in_xfer = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    slave_address = a; slave_writedata = d; slave_write = 1'b1;
    @(negedge clk);
    slave_write = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
    #1;
    slave_address = a; slave_read = 1'b1;
    #1;
    d = slave_readdata;
    slave_read = 1'b0;
  endtask

  // Reference model: pushes every expected write for a job
  task automatic push_expected(input logic [31:0] src, dst, input int chn, w, input logic avg);
    int wo, idx, v;
    longint acc;
    logic [31:0] res;
    wo = w / K; idx = 0;
    for (int c = 0; c < chn; c++)
      for (int oy = 0; oy < wo; oy++)
        for (int ox = 0; ox < wo; ox++) begin
          acc = 0;
          for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++) begin
              v = mem[(src >> 2) + (c*w + oy*K + ky)*w + ox*K + kx];
              if (avg) acc += v;
              else if ((ky == 0 && kx == 0) || v > acc) acc = v;
            end
          if (avg) acc = acc >>> (2*$clog2(K));
          res = acc[31:0];
          exp_q.push_back('{addr: dst + 32'(4*idx), data: res});
          idx++;
        end
  endtask

  task automatic run_job(input logic [31:0] src, dst, chn, w, input logic avg, ien,
                         input int budget, output int cyc);
    logic [31:0] st;
    reg_write(3'd1, src);
    reg_write(3'd2, dst);
    reg_write(3'd3, chn);
    reg_write(3'd4, w);
    rd_count = 0; wr_count = 0;
    reg_write(3'd0, {29'b0, ien, avg, 1'b1});
    cyc = 0; st = '0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      reg_read(3'd5, st);
      if (st[1]) begin cyc = i; break; end
    end
    check("job_done", {31'b0, st[1]}, 32'd1);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 16; i++) mem[64 + i] = i;
  endtask

  logic [31:0] rv;
  int cyc;

  initial begin : stim
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mread", {31'b0, master_read}, 32'd0);
    check("rst_mwrite", {31'b0, master_write}, 32'd0);
    check("rst_maddr", master_address, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_swait", {31'b0, slave_waitrequest}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 6; a++) begin
      reg_read(3'(a), rv);
      check($sformatf("rst_reg%0d", a), rv, 32'd0);
    end

    // Test 1: MAX on a 4x4 ramp
    load_ramp();
    push_expected(32'h100, 32'h800, 1, 4, 1'b0);
    run_job(32'h100, 32'h800, 1, 4, 1'b0, 1'b0, 24, cyc);
    check("t1_latency_le24", {31'b0, (cyc <= 24)}, 32'd1);
    check("t1_writes", 32'(wr_count), 32'd4);
    check("t1_reads", 32'(rd_count), 32'd16);
    check("t1_q_empty", 32'(exp_q.size()), 32'd0);
    check("t1_mem0", mem[512], 32'd0);
    reg_read(3'd0, rv);
    check("t1_ctrl_idle", rv, 32'd0);

    // Test 2: AVG on the ramp, then the negative window in both modes
    push_expected(32'h100, 32'h800, 1, 4, 1'b1);
    run_job(32'h100, 32'h800, 1, 4, 1'b1, 1'b0, 30, cyc);
    check("t2_q_empty", 32'(exp_q.size()), 32'd0);
    mem[192] = -1; mem[193] = -2; mem[194] = -2; mem[195] = -2;
    push_expected(32'h300, 32'h900, 1, 2, 1'b1);
    check("t2_model_avg_neg", exp_q[0].data, 32'hFFFF_FFFE);
    run_job(32'h300, 32'h900, 1, 2, 1'b1, 1'b0, 20, cyc);
    push_expected(32'h300, 32'h900, 1, 2, 1'b0);
    check("t2_model_max_neg", exp_q[0].data, 32'hFFFF_FFFF);
    run_job(32'h300, 32'h900, 1, 2, 1'b0, 1'b0, 20, cyc);
    check("t2_q_empty_neg", 32'(exp_q.size()), 32'd0);

    // Test 3: stalls on the 2nd read and the 1st write
    rd_stall_idx = 1; rd_stall_len = 3; wr_stall_idx = 0; wr_stall_len = 2;
    push_expected(32'h100, 32'h800, 1, 4, 1'b0);
    run_job(32'h100, 32'h800, 1, 4, 1'b0, 1'b0, 40, cyc);
    check("t3_reads", 32'(rd_count), 32'd16);
    check("t3_writes", 32'(wr_count), 32'd4);
    check("t3_q_empty", 32'(exp_q.size()), 32'd0);
    rd_stall_idx = -1; wr_stall_idx = -1;

    // Test 4: degenerate jobs
    run_job(32'h100, 32'h800, 0, 4, 1'b0, 1'b1, 3, cyc);
    check("t4a_no_xfer", 32'(rd_count + wr_count), 32'd0);
    check("t4a_irq", {31'b0, irq}, 32'd1);
    run_job(32'h100, 32'h800, 1, 1, 1'b0, 1'b0, 3, cyc);
    check("t4b_no_xfer", 32'(rd_count + wr_count), 32'd0);
    check("t4b_irq", {31'b0, irq}, 32'd0);
    reg_write(3'd5, 32'd0);
    reg_read(3'd5, rv);
    check("t4_status_clear", rv, 32'd0);

    // Test 5: W=5, CH=2 with mid-job register writes
    for (int i = 0; i < 50; i++) mem[256 + i] = $urandom;
    origin_a = 32'h460; origin_b = 32'h4C4; origin_reads = 0;
    push_expected(32'h400, 32'hA00, 2, 5, 1'b0);
    reg_write(3'd1, 32'h400);
    reg_write(3'd2, 32'hA00);
    reg_write(3'd3, 32'd2);
    reg_write(3'd4, 32'd5);
    rd_count = 0; wr_count = 0;
    reg_write(3'd0, 32'd1);
    repeat (4) @(negedge clk);
    reg_write(3'd0, 32'd7);
    reg_write(3'd1, 32'h000);
    begin : t5_wait
      rv = '0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        reg_read(3'd5, rv);
        if (rv[1]) break;
      end
      check("t5_done", {31'b0, rv[1]}, 32'd1);
    end
    check("t5_writes", 32'(wr_count), 32'd8);
    check("t5_reads", 32'(rd_count), 32'd32);
    check("t5_origin_unread", 32'(origin_reads), 32'd0);
    check("t5_q_empty", 32'(exp_q.size()), 32'd0);
    reg_read(3'd1, rv);
    check("t5_src_kept", rv, 32'h400);
    reg_read(3'd0, rv);
    check("t5_ctrl_kept", rv, 32'd0);
    origin_a = 32'hFFFF_FFF0; origin_b = 32'hFFFF_FFF0;

    // Test 6: reset in the middle of a read
    reg_write(3'd1, 32'h100);
    reg_write(3'd2, 32'h800);
    reg_write(3'd3, 32'd1);
    reg_write(3'd4, 32'd4);
    reg_write(3'd0, 32'd5);
    begin : t6_wait_rd
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (master_read) begin seen = 1'b1; break; end
      end
      check("t6_rd_seen", {31'b0, seen}, 32'd1);
    end
    #2 reset = 1'b0;
    #1;
    check("t6_mread_drop", {31'b0, master_read}, 32'd0);
    check("t6_mwrite_low", {31'b0, master_write}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 6; a++) begin
      reg_read(3'(a), rv);
      check($sformatf("t6_reg%0d", a), rv, 32'd0);
    end
    check("t6_irq", {31'b0, irq}, 32'd0);
    push_expected(32'h100, 32'h800, 1, 4, 1'b0);
    run_job(32'h100, 32'h800, 1, 4, 1'b0, 1'b0, 24, cyc);
    check("t6_writes", 32'(wr_count), 32'd4);
    check("t6_q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
